data_mem_param: RTL and testbench

DATA_MEM_PARAM -- requirements
Module: data_mem_param

---
 rtl/data_mem_param.sv | 142 ++++++++++++++
 tb/tb_data_mem_param.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_param.sv
// Purpose: byte-lane writable word memory with NUM_RD read ports and a self-clearing engine.
// Latency: reads are zero-cycle (REG_RD=0) or one-cycle registered (REG_RD=1); writes land at the clock edge.
// Backpressure: none; while the clear engine runs (busy) user writes are dropped and flagged on wr_drop.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (reset starts a full clear)
//   we, wbe, a, d     write enable, per-byte lane enables, write address, write data
//   dpra, dpo         packed read addresses / read data, slice k belongs to read port k
//   clr_req           request a full clear (honoured only when idle)
//   busy, wr_drop     clear engine running; one-cycle pulse after a discarded user write
module data_mem_param #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int NUM_RD = 2,
    parameter int REG_RD = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [DATA_W/8-1:0]      wbe,
    input  logic [ADDR_W-1:0]        a,
    input  logic [DATA_W-1:0]        d,
    input  logic [NUM_RD*ADDR_W-1:0] dpra,
    output logic [NUM_RD*DATA_W-1:0] dpo,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     wr_drop
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   w_ptr_nxt;
    logic                r_wr_drop;
    logic                w_usr_wr;
    logic                w_clr_wr;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    // Replace the lanes of old_w selected by be with the matching lanes of new_w.
    function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] old_w,
                                                  input logic [DATA_W-1:0] new_w,
                                                  input logic [NB-1:0]     be);
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign w_usr_wr = (r_state == ST_IDLE) && we;
    // The array is left untouched while reset is held; clearing starts on the
    // first edge after release.
    assign w_clr_wr = (r_state == ST_CLEAR) && rst_n;

    // ---------------- clear FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_CLEAR;
            r_ptr     <= '0;
            r_wr_drop <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_wr_drop <= we && (r_state == ST_CLEAR);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_CLEAR: begin
                // Pointer wraps to 0 naturally after the last word.
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == '1) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    assign busy    = (r_state == ST_CLEAR);
    assign wr_drop = r_wr_drop;

    // ---------------- storage ----------------
    always_ff @(posedge clk) begin
        if (w_clr_wr) begin
            r_mem[r_ptr] <= '0;
        end else if (w_usr_wr) begin
            r_mem[a] <= f_merge(r_mem[a], d, wbe);
        end
    end

    // ---------------- read ports ----------------
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rd;

        assign w_ra = dpra[k*ADDR_W +: ADDR_W];
        assign w_rd = r_mem[w_ra];

        if (REG_RD != 0) begin : g_reg
            logic [DATA_W-1:0] r_dpo;
            // Write-first: a same-cycle user write to the read address is
            // forwarded on its enabled lanes.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dpo <= '0;
                end else if (w_usr_wr && (a == w_ra)) begin
                    r_dpo <= f_merge(w_rd, d, wbe);
                end else begin
                    r_dpo <= w_rd;
                end
            end
            assign dpo[k*DATA_W +: DATA_W] = r_dpo;
        end else begin : g_comb
            assign dpo[k*DATA_W +: DATA_W] = w_rd;
        end
    end

endmodule

// File: tb/tb_data_mem_param.sv
module tb_data_mem_param;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int NR    = 2;
    localparam int DEPTH = 1 << AW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              we = 1'b0;
    logic [3:0]        wbe = 4'h0;
    logic [AW-1:0]     a = '0;
    logic [DW-1:0]     d = '0;
    logic [NR*AW-1:0]  dpra = '0;
    logic              clr_req = 1'b0;
    logic [NR*DW-1:0]  dpo0, dpo1;
    logic              busy0, busy1, wr_drop0, wr_drop1;

    always #5 clk = ~clk;

    data_mem_param #(.ADDR_W(AW), .DATA_W(DW), .NUM_RD(NR), .REG_RD(0)) u_comb (
        .clk(clk), .rst_n(rst_n), .we(we), .wbe(wbe), .a(a), .d(d),
        .dpra(dpra), .dpo(dpo0), .clr_req(clr_req), .busy(busy0), .wr_drop(wr_drop0));

    data_mem_param #(.ADDR_W(AW), .DATA_W(DW), .NUM_RD(NR), .REG_RD(1)) u_reg (
        .clk(clk), .rst_n(rst_n), .we(we), .wbe(wbe), .a(a), .d(d),
        .dpra(dpra), .dpo(dpo1), .clr_req(clr_req), .busy(busy1), .wr_drop(wr_drop1));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: array contents plus "words of the current clear still to go".
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_busy;
    int            m_left;
    bit            m_init = 1'b0;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [3:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [AW-1:0] ra(input int k);
        return dpra[k*AW +: AW];
    endfunction

    // One clock: predict, take the edge, update the model, check all outputs.
    task automatic step();
        logic [DW-1:0] exp1 [NR];
        bit            exp_drop;
        bit            init_before;
        int            idx;
        init_before = m_init;
        exp_drop    = we && m_busy;
        for (int k = 0; k < NR; k++) begin
            exp1[k] = m_mem[ra(k)];
            if (!m_busy && we && (a == ra(k))) exp1[k] = merge(m_mem[ra(k)], d, wbe);
        end
        @(posedge clk);
        if (m_busy) begin
            idx = DEPTH - m_left;
            m_mem[idx] = '0;
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_init = 1'b1;
            end
        end else begin
            if (we) m_mem[a] = merge(m_mem[a], d, wbe);
            if (clr_req) begin
                m_busy = 1'b1;
                m_left = DEPTH;
            end
        end
        #1;
        check("busy_comb", {31'd0, busy0}, {31'd0, m_busy});
        check("busy_reg", {31'd0, busy1}, {31'd0, m_busy});
        check("wr_drop_comb", {31'd0, wr_drop0}, {31'd0, exp_drop});
        check("wr_drop_reg", {31'd0, wr_drop1}, {31'd0, exp_drop});
        for (int k = 0; k < NR; k++) begin
            if (m_init) check("dpo_comb", dpo0[k*DW +: DW], m_mem[ra(k)]);
            if (init_before) check("dpo_reg", dpo1[k*DW +: DW], exp1[k]);
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        m_busy = 1'b1;
        m_left = DEPTH;
        #1;
        check("rst_busy_comb", {31'd0, busy0}, 32'd1);
        check("rst_busy_reg", {31'd0, busy1}, 32'd1);
        check("rst_wr_drop", {31'd0, wr_drop1}, 32'd0);
        check("rst_dpo_reg0", dpo1[DW-1:0], 32'd0);
        check("rst_dpo_reg1", dpo1[2*DW-1:DW], 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_until_idle(input string nm);
        int cnt;
        cnt = 0;
        while (busy0 && cnt < 100) begin
            step();
            cnt++;
        end
        check(nm, cnt, DEPTH);
    endtask

    typedef struct {
        logic          we;
        logic [3:0]    wbe;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [AW-1:0] ra;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{1'b1, 4'hF, 4'd5,  32'h11223344, 4'd5,  32'h11223344};
        vecs[1] = '{1'b1, 4'h5, 4'd5,  32'hAABBCCDD, 4'd5,  32'h11BB33DD};
        vecs[2] = '{1'b1, 4'h0, 4'd5,  32'hFFFFFFFF, 4'd5,  32'h11BB33DD};
        vecs[3] = '{1'b0, 4'hF, 4'd5,  32'h00000000, 4'd5,  32'h11BB33DD};
        vecs[4] = '{1'b1, 4'hF, 4'd9,  32'h12345678, 4'd9,  32'h12345678};
        vecs[5] = '{1'b1, 4'h8, 4'd15, 32'hCAFEF00D, 4'd15, 32'hCA000000};
        vecs[6] = '{1'b1, 4'h1, 4'd0,  32'h000000FF, 4'd0,  32'h000000FF};
        vecs[7] = '{1'b0, 4'h0, 4'd3,  32'h00000000, 4'd3,  32'h00000000};

        #2;
        do_reset();
        // Full clear after reset release: 16 busy cycles, then all zero.
        run_until_idle("reset_clear_len");
        for (int i = 0; i < DEPTH; i++) begin
            dpra = {AW'(i), AW'(i)};
            #1;
            check("post_clear_zero", dpo0[DW-1:0], 32'd0);
        end
        #1;

        // Table-driven writes, each followed by a read of both ports on both DUTs.
        foreach (vecs[i]) begin
            @(negedge clk);
            @(posedge clk);
            #1;
            we = vecs[i].we; wbe = vecs[i].wbe; a = vecs[i].a; d = vecs[i].d;
            dpra = {vecs[i].ra, vecs[i].ra};
            step();
            we = 1'b0;
            for (int k = 0; k < NR; k++) begin
                check("vec_comb", dpo0[k*DW +: DW], vecs[i].exp_rd);
                check("vec_reg", dpo1[k*DW +: DW], vecs[i].exp_rd);
            end
        end

        // Registered write-first forwarding.
        we = 1'b1; wbe = 4'hF; a = 4'd3; d = 32'hDEADBEEF; dpra = {4'd0, 4'd3};
        step();
        we = 1'b0;
        check("write_first_reg", dpo1[DW-1:0], 32'hDEADBEEF);

        // Equal read addresses: zero latency on comb DUT, one cycle on reg DUT.
        dpra = {4'd9, 4'd9};
        #1;
        check("lat0_p0", dpo0[DW-1:0], 32'h12345678);
        check("lat0_p1", dpo0[2*DW-1:DW], 32'h12345678);
        check("lat1_old", dpo1[DW-1:0], 32'hDEADBEEF);
        step();
        check("lat1_p0", dpo1[DW-1:0], 32'h12345678);
        check("lat1_p1", dpo1[2*DW-1:DW], 32'h12345678);

        // clr_req in idle; write on 3rd busy cycle is dropped; clr_req mid-clear ignored.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        check("clr_busy_rise", {31'd0, busy0}, 32'd1);
        step();
        step();
        we = 1'b1; wbe = 4'hF; a = 4'd2; d = 32'hFFFFFFFF;
        step();
        we = 1'b0;
        check("drop_pulse", {31'd0, wr_drop0}, 32'd1);
        step();
        check("drop_end", {31'd0, wr_drop1}, 32'd0);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        begin
            int cnt;
            cnt = 5;
            while (busy0 && cnt < 100) begin
                step();
                cnt++;
            end
            check("clr_len_ignore_req", cnt, DEPTH);
        end
        dpra = {4'd2, 4'd5};
        #1;
        check("dropped_word_zero", dpo0[DW-1:0], 32'd0);
        check("cleared_word_zero", dpo0[2*DW-1:DW], 32'd0);

        // Reset mid-clear at ptr=7 aborts and restarts a full clear.
        we = 1'b1; wbe = 4'hF; a = 4'd12; d = 32'h5A5A5A5A;
        step();
        we = 1'b0;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (7) step();
        check("ptr7_word12_intact", m_mem[12] === 32'h5A5A5A5A ? u_comb.r_mem[12] : 32'h0,
              32'h5A5A5A5A);
        dpra = {4'd15, 4'd15};
        do_reset();
        run_until_idle("restart_clear_len");
        dpra = {4'd12, 4'd6};
        #1;
        check("restart_word12", dpo0[DW-1:0], 32'd0);
        check("restart_word6", dpo0[2*DW-1:DW], 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            we      = 1'($urandom);
            wbe     = 4'($urandom);
            a       = AW'($urandom);
            d       = $urandom;
            dpra    = (NR*AW)'($urandom);
            clr_req = ($urandom_range(0, 39) == 0);
            step();
        end
        we = 1'b0; clr_req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
